// File: rtl/rng_share_pkg.sv
// Shared helpers for the Sobol random-number fan-out array: rotation and
// sizing functions evaluated at elaboration time by the top module.
package rng_share_pkg;

  // Widest RNG word the rotation helper handles.
  localparam int MAX_RWID = 32;

  // Number of delay-line stages needed so the last buffer can tap (TDIM-1)*SKEW.
  function automatic int delay_depth(input int tdim, input int skew);
    return (tdim - 1) * skew + 1;
  endfunction

  // Fill counter must reach delay_depth, the first value at which every buffer is valid.
  function automatic int fill_width(input int tdim, input int skew);
    return $clog2((tdim - 1) * skew + 2);
  endfunction

  // Rotate the low 'width' bits of 'value' left by 'amount'; upper bits return 0.
  function automatic logic [MAX_RWID-1:0] rotl(input logic [MAX_RWID-1:0] value,
                                               input int amount,
                                               input int width);
    logic [MAX_RWID-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_RWID; b++) begin
      if (b < width) r[(b + amount) % width] = value[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/rng_skew_share_array_sobol.sv
// Dimension-1 Sobol generator with synchronous restart. Each enabled step
// XORs in the direction number selected by the lowest zero bit of the index;
// n_wrap flags that the next step returns the index (and the word) to 0.
module SobolRngDim1 #(
  parameter int RWID = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            clear,
  output logic [RWID-1:0] x,
  output logic            n_wrap
);

  logic [RWID-1:0] n;
  logic [RWID-1:0] dir;

  // Direction number v[c] = 2^(RWID-1-c), c = position of the lowest zero bit of n.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    dir = '0;
    for (int b = RWID - 1; b >= 0; b--) begin
      if (!n[b]) begin
        dir           = '0;
        dir[RWID-1-b] = 1'b1;
      end
    end
  end

  // All-ones index has no zero bit: the next step closes the period.
  assign n_wrap = &n;

  // Generator state: restart on clear, step on enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      x <= '0;
      n <= '0;
    end else if (clear) begin
      x <= '0;
      n <= '0;
    end else if (enable) begin
      x <= n_wrap ? '0 : (x ^ dir);
      n <= n + RWID'(1);
    end
  end

endmodule

// File: rtl/rng_skew_share_array.sv
// Sobol random-number fan-out: one generator feeds a registered delay line,
// TDIM buffers tap it at multiples of SKEW enabled cycles, and each buffer is
// shared by SDIM consumers with optional per-buffer left rotation.
module rng_skew_share_array
  import rng_share_pkg::*;
#(
  parameter  int RWID = 10,
  parameter  int BDIM = 32,
  parameter  int SDIM = 32,
  parameter  int SKEW = 1,
  localparam int TDIM = (BDIM < 1) ? 1 : BDIM
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      rotEn,
  output logic [TDIM*SDIM*RWID-1:0] rngSeq,
  output logic [TDIM-1:0]           rngValid,
  output logic                      periodDone
);

  localparam int            DEPTH    = delay_depth(TDIM, SKEW);
  localparam int            FW       = fill_width(TDIM, SKEW);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  logic [RWID-1:0] gen_x;
  logic            gen_wrap;
  logic [FW-1:0]   fill;

  SobolRngDim1 #(.RWID(RWID)) u_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .clear  (clear),
    .x      (gen_x),
    .n_wrap (gen_wrap)
  );

  // Delay line: stage 0 captures the generator word, later stages shift it along.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [RWID-1:0] q;
    logic [RWID-1:0] d;
    if (k == 0) begin : g_head
      assign d = gen_x;
    end else begin : g_tail
      assign d = g_stage[k-1].q;
    end

    // One delay stage, advanced only on enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the delay line is reset (not left as raw storage) so rngSeq reads 0 after reset/clear.
      if (!rst_n)      q <= '0;
      else if (clear)  q <= '0;
      else if (enable) q <= d;
    end
  end

  // Saturating count of enabled cycles since reset/clear, drives the fill flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          fill <= '0;
    else if (clear)                      fill <= '0;
    else if (enable && fill != FILL_MAX) fill <= fill + FW'(1);
  end

  // One-cycle pulse after the enabled step that returns the generator to x=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     periodDone <= 1'b0;
    else if (clear) periodDone <= 1'b0;
    else            periodDone <= enable & gen_wrap;
  end

  // Buffer taps and consumer fan-out; rotation stays combinational on rotEn.
  for (genvar i = 0; i < TDIM; i++) begin : g_buf
    localparam int TAP = i * SKEW;
    logic [RWID-1:0] tap_q;
    logic [RWID-1:0] tap_rot;

    assign tap_q       = g_stage[TAP].q;
    assign tap_rot     = RWID'(rotl(MAX_RWID'(tap_q), i % RWID, RWID));
    assign rngValid[i] = (fill > FW'(TAP));

    for (genvar j = 0; j < SDIM; j++) begin : g_cons
      assign rngSeq[(i*SDIM+j)*RWID +: RWID] = rotEn ? tap_rot : tap_q;
    end
  end

endmodule

// File: tb/tb_rng_skew_share_array.sv
// Scoreboard bench for rng_skew_share_array. The driver advances one clock per
// step, updates a Gray-code reference model and queues expected outputs for
// that cycle; the monitor samples on the falling edge and retires them.
module tb_rng_skew_share_array;

  localparam int RW  = 10;
  localparam int SD  = 2;
  localparam int SK  = 1;
  localparam int TD  = 4;
  localparam int SDB = 3;

  typedef enum int {K_WORD_A, K_VALID_A, K_PD_A, K_WORD_B, K_VALID_B, K_PD_B, K_HIST} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b1, enable = 1'b0, clear = 1'b0, rotEn = 1'b0;
  logic [TD*SD*RW-1:0] seq_a;
  logic [TD-1:0]       valid_a;
  logic                pd_a;
  logic [SDB*RW-1:0]   seq_b;
  logic                valid_b;
  logic                pd_b;

  exp_t sb[$];
  int   cyc = 0, n_cmp = 0, n_bad = 0, k = 0;
  logic pd_m = 1'b0;
  bit   done = 1'b0;
  int   hist[1024];
  int   hist_lo = -1, hist_hi = -1;

  logic [9:0] tbl  [5] = '{10'd0, 10'd512, 10'd768, 10'd256, 10'd384};
  logic [3:0] tblv [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

  rng_skew_share_array #(.RWID(RW), .BDIM(TD), .SDIM(SD), .SKEW(SK)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .rotEn(rotEn),
    .rngSeq(seq_a), .rngValid(valid_a), .periodDone(pd_a)
  );

  rng_skew_share_array #(.RWID(RW), .BDIM(0), .SDIM(SDB), .SKEW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .rotEn(rotEn),
    .rngSeq(seq_b), .rngValid(valid_b), .periodDone(pd_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sobol dim-1 word m = bit-reverse of Gray code of m.
  function automatic logic [9:0] sobol_ref(input int m);
    logic [9:0] g, r;
    g = 10'(m) ^ 10'(m >> 1);
    for (int b = 0; b < 10; b++) r[b] = g[9-b];
    return r;
  endfunction

  function automatic logic [9:0] rotl_ref(input logic [9:0] v, input int r);
    if (r == 0) return v;
    return (v << r) | (v >> (10 - r));
  endfunction

  // Word held by a buffer that lags the generator by d enabled steps.
  function automatic logic [9:0] bufval(input int d);
    int m;
    m = k - 1 - d;
    if (m < 0) return 10'd0;
    return sobol_ref(m % 1024);
  endfunction

  task automatic push(input kind_e kd, input int idx, input logic [31:0] e);
    exp_t t;
    t.cyc = cyc; t.kind = kd; t.idx = idx; t.exp = e;
    sb.push_back(t);
  endtask

  task automatic push_all(input logic rot);
    logic [31:0] vv;
    vv = '0;
    for (int i = 0; i < TD; i++) begin
      logic [9:0] w;
      w = bufval(i * SK);
      push(K_WORD_A, i * SD + (i % SD), 32'(rot ? rotl_ref(w, i % RW) : w));
      vv[i] = (k > i * SK);
    end
    push(K_VALID_A, 0, vv);
    push(K_PD_A, 0, 32'(pd_m));
    for (int j = 0; j < SDB; j++) push(K_WORD_B, j, 32'(bufval(0)));
    push(K_VALID_B, 0, 32'(k > 0));
    push(K_PD_B, 0, 32'(pd_m));
  endtask

  // One clock: enable/clear act at the edge, rotEn changes just after it.
  task automatic step(input logic en, input logic clr, input logic rot);
    enable = en;
    clear  = clr;
    @(posedge clk); #2;
    rotEn = rot;
    if (clr) begin
      k = 0; pd_m = 1'b0;
    end else if (en) begin
      k++; pd_m = (k % 1024 == 0);
    end else begin
      pd_m = 1'b0;
    end
    push_all(rot);
  endtask

  // Monitor: record histogram samples, then retire every entry due this cycle.
  always @(negedge clk) begin
    exp_t        t;
    logic [31:0] act;
    int          uniq;
    if (hist_lo >= 0 && cyc >= hist_lo && cyc <= hist_hi)
      hist[seq_a[RW-1:0]] = hist[seq_a[RW-1:0]] + 1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      t = sb.pop_front();
      case (t.kind)
        K_WORD_A:  act = 32'(seq_a[t.idx*RW +: RW]);
        K_VALID_A: act = 32'(valid_a);
        K_PD_A:    act = 32'(pd_a);
        K_WORD_B:  act = 32'(seq_b[t.idx*RW +: RW]);
        K_VALID_B: act = 32'(valid_b);
        K_PD_B:    act = 32'(pd_b);
        default: begin
          uniq = 0;
          for (int v = 0; v < 1024; v++) if (hist[v] == 1) uniq++;
          act = 32'(uniq);
        end
      endcase
      n_cmp++;
      if (t.cyc != cyc || act !== t.exp) begin
        n_bad++;
        $display("FAIL %s[%0d] cycle %0d (due %0d): got %0h, expected %0h",
                 t.kind.name(), t.idx, cyc, t.cyc, act, t.exp);
      end
    end
  end

  initial begin
    foreach (hist[v]) hist[v] = 0;
    #1 rst_n = 1'b0;
    @(posedge clk); #2; push_all(1'b0);
    @(posedge clk); #2; push_all(1'b0);
    rst_n = 1'b1;

    // First words and fill flags after reset.
    for (int s = 1; s <= 6; s++) begin
      step(1'b1, 1'b0, 1'b0);
      if (s <= 5) push(K_WORD_A, 0, 32'(tbl[s-1]));
      if (s <= 4) push(K_VALID_A, 0, 32'(tblv[s-1]));
    end
    // Rotation with every buffer filled, then back.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Enable gaps stretch the skew.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Clear together with enable after 50 enabled cycles.
    while (k < 50) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0); push(K_WORD_A, 0, 32'd0);
    step(1'b1, 1'b0, 1'b0); push(K_WORD_A, 0, 32'd512);

    // Buffer 1 holds 512: rotated consumers read 1, then 512 again.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int j = 0; j < SD; j++) push(K_WORD_A, SD + j, 32'd1);
    step(1'b0, 1'b0, 1'b0);
    for (int j = 0; j < SD; j++) push(K_WORD_A, SD + j, 32'd512);

    // Asynchronous reset mid-stream.
    repeat (5) step(1'b1, 1'b0, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0; k = 0; pd_m = 1'b0;
    @(posedge clk); #2; push_all(1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0); push(K_WORD_A, 0, 32'd0);
    step(1'b1, 1'b0, 1'b0); push(K_WORD_A, 0, 32'd512);

    // Full period: every value once, single periodDone pulse at step 1024.
    step(1'b0, 1'b1, 1'b0);
    hist_lo = cyc + 1;
    hist_hi = cyc + 1024;
    repeat (1024) step(1'b1, 1'b0, 1'b0);
    push(K_HIST, 0, 32'd1024);

    // Wrap on the same cycle as clear: no pulse.
    repeat (1023) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    enable = 1'b0;

    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      n_bad++;
      $display("FAIL watchdog: run still active at %0t, expected finish", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

endmodule

// File: doc/rng_skew_share_array.md
# rng_skew_share_array

Parametrised Sobol random-number fan-out array feeding the unary FC-layer multiplier banks. One dimension-1 Sobol generator drives a registered delay line. Each of TDIM buffers taps the line at a distinct, configurable cycle skew, which decorrelates the buffers in time. Each buffer is shared by SDIM consumers, with optional per-buffer bit rotation. The block adds synchronous restart, per-buffer fill-valid flags and an end-of-period pulse for stream-length control.

## Interface
- RWID, 10: RNG word width; generator period is 2^RWID enabled cycles.
- BDIM, 32: requested buffer count.
- TDIM, (BDIM < 1) ? 1 : BDIM: true buffer count; derived, never overridden.
- SDIM, 32: consumers sharing each buffer.
- SKEW, 1: delay in enabled cycles between consecutive buffers; 0 gives all buffers the same sequence.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  advances generator, delay line, fill counter and period counter.
- clear  in  1  synchronous restart to the reset state; has priority over enable.
- rotEn  in  1  rotation mode; quasi-static, sampled combinationally.
- rngSeq  out  RWID x (TDIM*SDIM)  shared random words; index i*SDIM+j belongs to buffer i.
- rngValid  out  TDIM  buffer i holds generator-derived data since the last reset/clear.
- periodDone  out  1  single-cycle pulse at generator wrap.

## Operation
- Generator (SobolRngDim1): state x and index n, both reset to 0.
  - On each enabled cycle: x <= x XOR v[c], where c = position of the least-significant 0 bit of n, v[c] = 2^(RWID-1-c), and n <= n+1 (mod 2^RWID).
  - RWID=10 sequence from reset: 0, 512, 768, 256, 384, ...
- Delay line: stages 0..(TDIM-1)*SKEW, each RWID bits, reset 0.
  - When enabled, stage 0 <= x and stage k <= stage k-1.
  - Buffer i = stage i*SKEW.
- Output mapping: rngSeq[i*SDIM+j] = buffer i if rotEn=0, else buffer i rotated left by (i mod RWID) bits.
  - Rotation preserves full-period uniformity.
- Fill counter: saturating, width $clog2((TDIM-1)*SKEW+2), counts enabled cycles.
  - rngValid[i] = (fill > i*SKEW).
- periodDone: asserted for one cycle in the cycle after an enabled step in which n goes from 2^RWID-1 to 0; the generator is back at x=0 at that point.
- clear=1: generator, delay line, fill counter and periodDone go to reset values on the next edge, regardless of enable.
- enable=0 and clear=0: all state holds and periodDone is 0.

## Timing
- Reset values: rngSeq all 0, rngValid all 0, periodDone 0.
- Buffer i latency: 1 + i*SKEW enabled cycles from generator state to buffer register.
- rngValid[i] rises on the edge of the (1+i*SKEW)-th enabled cycle after reset/clear, stays high until reset/clear, and saturates.
- Gaps in enable stretch every latency; skew is measured in enabled cycles only.
- clear and enable in the same cycle: clear wins; no step is taken.
- Async reset mid-stream: every register goes to 0 immediately; the stream restarts from x=0 after release.
- Wrap on the same cycle as clear: no periodDone pulse.
- rotEn change: rngSeq responds in the same cycle (combinational); no state change.

## Structure
- Package rng_share_pkg:
  - function rotl(value, amount, width)
  - localparam helpers: delay depth (TDIM-1)*SKEW+1 and fill-counter width.
- Sub-module: SobolRngDim1, extended with a clear input and an exported n-wrap flag.
- Delay line and output fan-out are generate loops in the top module.

## Test plan
- Reset, RWID=10, TDIM=4, SKEW=1, enable held high -> buffer 0 reads 0, 512, 768, 256, 384 on successive cycles; buffer 3 shows the same values 3 cycles later; rngValid goes 0001, 0011, 0111, 1111.
- Run 1024 enabled cycles -> periodDone pulses exactly once, at cycle 1024; buffer 0 histogram covers each value 0..1023 exactly once.
- rotEn=1, buffer 1 value 512 -> consumers 1*SDIM..2*SDIM-1 read 1 (rotl 512 by 1, RWID=10); toggling rotEn back returns 512 the same cycle.
- enable toggled 1,0,0,1 -> outputs and rngValid freeze during the 0 cycles; buffer 1 still lags buffer 0 by one enabled step.
- clear asserted with enable after 50 cycles -> next edge: all rngSeq 0, rngValid 0; stream restarts at 0, 512, ...
- SKEW=0, BDIM=0 -> TDIM=1; all SDIM outputs are identical; rngValid[0] is set after the first enabled cycle.
